track_recorder: RTL
===================

Name: track_recorder

Overview:
- Record-side counterpart of the note-track playback path. Playback reads 4-bit track words from RAM and shifts them out one step per game beat; this block writes those words.
- Samples one player key each game beat and packs WORD_W consecutive beats into one track word.
- Writes each completed word to the track RAM write port (address/data/wren), so a player-recorded pattern can be played back later.

Parameters:
ADDR_W, 7, track RAM address width; DEPTH = 2**ADDR_W words
WORD_W, 4, beats per RAM word (= track RAM data width)

Ports:
CLK  input  1  system clock (CLOCK_50 domain)
RESET_N  input  1  asynchronous, active-low reset
beat_tick  input  1  one-CLK-cycle strobe per game step (CLOCK_LINE rate)
start  input  1  one-cycle pulse: begin recording at address 0
stop  input  1  one-cycle pulse: end recording, flushing any partial word
key_n  input  1  raw player button, active-low (KEY style), asynchronous to CLK
ram_address  output  ADDR_W  write address to track RAM
ram_data  output  WORD_W  write data to track RAM
ram_wren  output  1  RAM write enable, one-cycle pulse
recording  output  1  high in RECORD and FLUSH
full  output  1  high once word DEPTH-1 has been written
words_written  output  ADDR_W+1  count of words written since last start

Behaviour:
- Reset (async, RESET_N=0): all outputs 0; state IDLE; step counter, word register, hit flag and write pointer cleared. A partially assembled word is discarded and never written.
- Input sync: key_n passes through a 2-flop synchronizer; pressed = ~synced. Press-to-sample latency is 2 CLK cycles.
- Bit order: beat i of a word (i = 0..WORD_W-1) goes to ram_data[i]. Beat 0 lands in bit 0, which is the first bit playback presents to the player.
- States: IDLE, RECORD, FLUSH, DONE.
- IDLE / DONE:
  - start=1 and stop=0 -> RECORD; write pointer, step, words_written and full cleared.
  - start together with stop -> ignored.
  - beat_tick ignored.
- RECORD:
  - Sticky hit flag is set by pressed on any cycle.
  - On beat_tick: word[step] <= hit | pressed; hit cleared; step++.
  - Capture window is from the cycle after the previous beat_tick up to and including the current beat_tick cycle.
  - start is ignored.
- Write on completed word: when beat_tick fills step WORD_W-1:
  - The next cycle has ram_wren=1 for exactly one cycle, ram_address=write pointer, ram_data=completed word. All three are registered and stable during that cycle.
  - The write pointer and words_written increment after the write.
  - step wraps to 0 and the word register clears.
  - A beat_tick arriving in the wren cycle is captured normally into the new word (step 0). No beat is lost.
- Full:
  - If the completed write used address DEPTH-1, then in the same cycle as that wren: full=1 and state -> DONE.
  - Further beat_ticks produce no writes. The address never wraps.
- stop in RECORD:
  - step=0 -> DONE, no write.
  - step>0 -> FLUSH. The next cycle issues one wren with the partial word; unfilled high bits are 0. Then -> DONE, and words_written increments.
  - stop in the same cycle as a word-completing beat_tick: the completed word is written; step is then 0, so go to DONE with no extra write.
  - stop in FLUSH or DONE is ignored.
- recording is 1 exactly in RECORD and FLUSH.
- ram_data and ram_address hold their last written values between pulses. ram_wren is never high for two consecutive cycles except when a completing write is followed immediately by a FLUSH write.

Test Plan:
1. Reset, start; hold key_n=0 across beats 0 and 2 only, release for beats 1 and 3. After the 4th beat_tick, the next cycle shows ram_wren=1, ram_address=0, ram_data=4'b0101; words_written=1.
2. Key pressed for 1 CLK cycle, 5 cycles after beat 0's tick, then released. Beat 1 captures 1 and the word is 4'b0010: the sticky hit works and the synchronizer has no glitch loss.
3. Record 6 beats, all pressed, then pulse stop. Writes are addr0=4'b1111 and addr1=4'b0011. Then DONE, recording=0, words_written=2.
4. ADDR_W=2: 16 pressed beats give 4 writes to addresses 0..3, and full=1 in the same cycle as the last wren. Beats 17-20 produce no wren; ram_address stays 3.
5. Reset asserted after 2 beats of a word. No wren occurs and all outputs are 0. After start, the first write goes to address 0 with no stale bits.
6. start pulsed mid-RECORD has no effect: the pointer continues. After DONE, start restarts at address 0 with full=0 and words_written=0.

Source files
------------

// File: rtl/track_recorder.sv
// Samples one player key per game beat and packs WORD_W beats into track RAM words.
// States: IDLE idle | RECORD sampling beats | FLUSH writing partial word | DONE stopped or full
module track_recorder #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              beat_tick,
  input  logic              start,
  input  logic              stop,
  input  logic              key_n,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              recording,
  output logic              full,
  output logic [ADDR_W:0]   words_written
);

  localparam int STEP_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, RECORD, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic                key_s1_q, key_s2_q;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                hit_q, hit_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                full_q, full_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;

  logic                pressed;
  logic                completing;
  logic [STEP_W-1:0]   step_after;
  logic [WORD_W-1:0]   word_next;

  assign pressed    = ~key_s2_q;
  assign completing = beat_tick && (step_q == STEP_LAST);
  assign step_after = completing ? '0 : (step_q + STEP_W'(beat_tick));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      step_q   <= '0;
      word_q   <= '0;
      hit_q    <= 1'b0;
      wptr_q   <= '0;
      words_q  <= '0;
      full_q   <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      step_q   <= step_d;
      word_q   <= word_d;
      hit_q    <= hit_d;
      wptr_q   <= wptr_d;
      words_q  <= words_d;
      full_q   <= full_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start && !stop) state_d = RECORD;
      RECORD: begin
        if (completing && (wptr_q == ADDR_LAST)) state_d = DONE;
        else if (stop) state_d = (step_after == '0) ? DONE : FLUSH;
      end
      FLUSH: state_d = DONE;
    endcase
  end

  always_comb begin
    step_d    = step_q;
    word_d    = word_q;
    hit_d     = hit_q;
    wptr_d    = wptr_q;
    words_d   = words_q;
    full_d    = full_q;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    word_next = word_q;
    word_next[step_q] = hit_q | pressed;
    recording = (state_q == RECORD) || (state_q == FLUSH);
    case (state_q)
      IDLE, DONE: begin
        hit_d = 1'b0;
        if (start && !stop) begin
          step_d  = '0;
          word_d  = '0;
          wptr_d  = '0;
          words_d = '0;
          full_d  = 1'b0;
        end
      end
      RECORD: begin
        hit_d = hit_q | pressed;
        if (beat_tick) begin
          hit_d = 1'b0;
          if (completing) begin
            wren_d  = 1'b1;
            addr_d  = wptr_q;
            data_d  = word_next;
            wptr_d  = wptr_q + 1'b1;
            words_d = words_q + 1'b1;
            full_d  = full_q | (wptr_q == ADDR_LAST);
            step_d  = '0;
            word_d  = '0;
          end else begin
            step_d = step_after;
            word_d = word_next;
          end
        end
      end
      FLUSH: begin
        // Unfilled high bits are already zero in word_q.
        wren_d  = 1'b1;
        addr_d  = wptr_q;
        data_d  = word_q;
        wptr_d  = wptr_q + 1'b1;
        words_d = words_q + 1'b1;
        full_d  = full_q | (wptr_q == ADDR_LAST);
        step_d  = '0;
        word_d  = '0;
        hit_d   = 1'b0;
      end
    endcase
  end

  assign ram_address   = addr_q;
  assign ram_data      = data_q;
  assign ram_wren      = wren_q;
  assign full          = full_q;
  assign words_written = words_q;

endmodule
